// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// RISC-V load/store funct3 encodings and the fixed data width.
package lsu_pkg;

  localparam int N_BIT = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane steering between a memory word and byte/halfword accesses:
// extracts and extends load data, and merges sub-word store data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]       offset,
  input  logic [2:0]       funct3,
  input  logic [N_BIT-1:0] mem_word,
  input  logic [N_BIT-1:0] store_data,
  output logic [N_BIT-1:0] load_data,
  output logic [N_BIT-1:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? mem_word[31:16] : mem_word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data = mem_word;
      F3_BU:   load_data = {24'b0, byte_sel};
      F3_HU:   load_data = {16'b0, half_sel};
      default: load_data = '0;
    endcase
  end

  // Memory has no byte enables, so sub-word stores rewrite the whole word
  always_comb begin
    merged_word = mem_word;
    case (funct3)
      F3_B: merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
      F3_H: begin
        if (offset[1]) merged_word[31:16] = store_data[15:0];
        else           merged_word[15:0]  = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Converts byte-addressed RISC-V loads/stores into word accesses on a
// memory without byte enables, using read-modify-write for SB/SH.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int N_ADDR = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [N_BIT-1:0]  req_wdata,
  output logic              resp_valid,
  output logic [N_BIT-1:0]  resp_rdata,
  output logic              resp_err,
  output logic [N_ADDR-1:0] mem_addr,
  output logic [N_BIT-1:0]  mem_wr_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [N_BIT-1:0]  mem_rd_data
);

  state_t           state;
  logic             lat_we;
  logic [2:0]       lat_f3;
  logic [1:0]       lat_off;
  logic [N_BIT-1:0] lat_wdata;

  logic             addr_oob;
  logic             misaligned;
  logic             bad_f3;
  logic             req_err;
  logic [N_BIT-1:0] load_data;
  logic [N_BIT-1:0] merged_word;

  // Gated by Rst so the unit never advertises readiness while held in reset
  assign req_ready = Rst && (state == S_IDLE);

  always_comb begin
    addr_oob   = |req_addr[31:N_ADDR+2];
    misaligned = 1'b0;
    if (req_funct3 == F3_W)
      misaligned = (req_addr[1:0] != 2'b00);
    else if (req_funct3 == F3_H || req_funct3 == F3_HU)
      misaligned = req_addr[0];
    if (req_we)
      bad_f3 = (req_funct3 > F3_W);
    else
      bad_f3 = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
    req_err = addr_oob || misaligned || bad_f3;
  end

  lsu_align u_align (
    .offset      (lat_off),
    .funct3      (lat_f3),
    .mem_word    (mem_rd_data),
    .store_data  (lat_wdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state       <= S_IDLE;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      lat_we      <= 1'b0;
      lat_f3      <= '0;
      lat_off     <= '0;
      lat_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we     <= req_we;
            lat_f3     <= req_funct3;
            lat_off    <= req_addr[1:0];
            lat_wdata  <= req_wdata;
            mem_addr   <= req_addr[N_ADDR+1:2];
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end else if (!req_we || req_funct3 != F3_W) begin
              mem_read <= 1'b1;
              state    <= S_RD;
            end else begin
              mem_write   <= 1'b1;
              mem_wr_data <= req_wdata;
              state       <= S_WR;
            end
          end
        end
        S_RD: begin
          mem_read <= 1'b0;
          state    <= S_CAP;
        end
        S_CAP: begin
          if (lat_we) begin
            mem_wr_data <= merged_word;
            mem_write   <= 1'b1;
            state       <= S_WR;
          end else begin
            resp_rdata <= load_data;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_WR: begin
          mem_write  <= 1'b0;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of load/store vectors with
// a response scoreboard, plus hand-written reset sequences.
module tb_load_store_unit;

  localparam int N_ADDR = 8;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [N_ADDR-1:0] mem_addr;
  logic [31:0]       mem_wr_data;
  logic              mem_write;
  logic              mem_read;
  logic [31:0]       mem_rd_data;
  logic              mem_init;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          reads;
    int          writes;
    int          rd_off;
    int          wr_off;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc = 0;
  int n_reads = 0;
  int n_writes = 0;
  int rd_off = -1;
  int wr_off = -1;
  int resp_count = 0;
  bit overlap = 1'b0;
  bit done = 1'b0;

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  load_store_unit #(.N_ADDR(N_ADDR)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .mem_rd_data (mem_rd_data)
  );

  // Word memory: read data registered one edge after mem_read, X otherwise
  logic [31:0] mem [0:255];
  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[5] <= 32'h8899AABB;
      mem[8] <= 32'hCAFEF00D;
      mem[9] <= 32'h01234567;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wr_data;
    end
    mem_rd_data <= mem_read ? mem[mem_addr] : 32'hxxxxxxxx;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (mem_read) begin
      n_reads++;
      rd_off = cyc - acc;
    end
    if (mem_write) begin
      n_writes++;
      wr_off = cyc - acc;
    end
    if (mem_read && mem_write) overlap = 1'b1;
    if (resp_valid) begin
      resp_count++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("v%0d_rdata", e.idx), resp_rdata, e.rdata);
        checkOutput($sformatf("v%0d_err", e.idx), {31'b0, resp_err}, {31'b0, e.err});
        checkOutput($sformatf("v%0d_latency", e.idx), cyc - acc, e.lat);
        checkOutput($sformatf("v%0d_reads", e.idx), n_reads, e.reads);
        checkOutput($sformatf("v%0d_writes", e.idx), n_writes, e.writes);
        checkOutput($sformatf("v%0d_rd_cycle", e.idx), rd_off, e.rd_off);
        checkOutput($sformatf("v%0d_wr_cycle", e.idx), wr_off, e.wr_off);
        checkOutput($sformatf("v%0d_rd_wr_overlap", e.idx), {31'b0, overlap}, 32'd0);
      end
      done = 1'b1;
    end
  end

  function automatic exp_t makeExp(input vec_t v, input int idx);
    exp_t e;
    e.idx = idx;
    e.rdata = v.rdata;
    e.err = v.err;
    if (v.err) begin
      e.lat = 1; e.reads = 0; e.writes = 0; e.rd_off = -1; e.wr_off = -1;
    end else if (v.we && v.f3 == 3'd2) begin
      e.lat = 2; e.reads = 0; e.writes = 1; e.rd_off = -1; e.wr_off = 1;
    end else if (v.we) begin
      e.lat = 4; e.reads = 1; e.writes = 1; e.rd_off = 1; e.wr_off = 3;
    end else begin
      e.lat = 3; e.reads = 1; e.writes = 0; e.rd_off = 1; e.wr_off = -1;
    end
    return e;
  endfunction

  task automatic addVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx, input bit push);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge Clk);
    if (!req_ready) checkOutput($sformatf("v%0d_ready_wait", idx), {31'b0, req_ready}, 32'd1);
    n_reads = 0; n_writes = 0; rd_off = -1; wr_off = -1; overlap = 1'b0; done = 1'b0;
    acc = cyc;
    req_valid = 1'b1;
    req_we = v.we;
    req_funct3 = v.f3;
    req_addr = v.addr;
    req_wdata = v.wdata;
    if (push) exp_q.push_back(makeExp(v, idx));
    @(posedge Clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic waitResponse(input int idx);
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge Clk);
      #1;
    end
    if (!done) begin
      checkOutput($sformatf("v%0d_resp_timeout", idx), 32'd0, 32'd1);
      exp_q.delete();
    end else begin
      @(negedge Clk);
      checkOutput($sformatf("v%0d_ready_after", idx), {31'b0, req_ready}, 32'd1);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
    checkOutput({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    checkOutput({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    checkOutput({tag, "_mem_read"}, {31'b0, mem_read}, 32'd0);
    checkOutput({tag, "_mem_write"}, {31'b0, mem_write}, 32'd0);
    checkOutput({tag, "_mem_addr"}, {24'b0, mem_addr}, 32'd0);
    checkOutput({tag, "_mem_wr_data"}, mem_wr_data, 32'd0);
  endtask

  initial begin
    vec_t v;
    int   saved_resp;

    Rst = 1'b0;
    mem_init = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'h0;
    req_wdata = 32'h0;

    // we, funct3, addr, wdata, expected rdata, expected err
    addVec(1'b0, 3'd0, 32'h15, 32'h0, 32'hFFFFFFAA, 1'b0);
    addVec(1'b0, 3'd5, 32'h16, 32'h0, 32'h00008899, 1'b0);
    addVec(1'b0, 3'd1, 32'h16, 32'h0, 32'hFFFF8899, 1'b0);
    addVec(1'b0, 3'd4, 32'h17, 32'h0, 32'h00000088, 1'b0);
    addVec(1'b0, 3'd2, 32'h14, 32'h0, 32'h8899AABB, 1'b0);
    addVec(1'b1, 3'd0, 32'h14, 32'h12345611, 32'h0, 1'b0);
    addVec(1'b0, 3'd2, 32'h14, 32'h0, 32'h8899AA11, 1'b0);
    addVec(1'b1, 3'd1, 32'h16, 32'hFFFF7766, 32'h0, 1'b0);
    addVec(1'b0, 3'd2, 32'h14, 32'h0, 32'h7766AA11, 1'b0);
    addVec(1'b0, 3'd0, 32'h14, 32'h0, 32'h00000011, 1'b0);
    addVec(1'b0, 3'd1, 32'h14, 32'h0, 32'hFFFFAA11, 1'b0);
    addVec(1'b1, 3'd2, 32'h3FC, 32'hDEADBEEF, 32'h0, 1'b0);
    addVec(1'b0, 3'd2, 32'h3FC, 32'h0, 32'hDEADBEEF, 1'b0);
    addVec(1'b0, 3'd0, 32'h3FF, 32'h0, 32'hFFFFFFDE, 1'b0);
    addVec(1'b1, 3'd1, 32'h02, 32'h00008001, 32'h0, 1'b0);
    addVec(1'b0, 3'd2, 32'h00, 32'h0, 32'h80010000, 1'b0);
    addVec(1'b0, 3'd1, 32'h02, 32'h0, 32'hFFFF8001, 1'b0);
    addVec(1'b0, 3'd4, 32'h03, 32'h0, 32'h00000080, 1'b0);
    addVec(1'b1, 3'd0, 32'h27, 32'h000000AB, 32'h0, 1'b0);
    addVec(1'b0, 3'd2, 32'h24, 32'h0, 32'hAB234567, 1'b0);
    addVec(1'b0, 3'd2, 32'h02, 32'h0, 32'h0, 1'b1);
    addVec(1'b1, 3'd1, 32'h01, 32'h1234, 32'h0, 1'b1);
    addVec(1'b0, 3'd3, 32'h00, 32'h0, 32'h0, 1'b1);
    addVec(1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1'b1);
    addVec(1'b1, 3'd4, 32'h00, 32'h55, 32'h0, 1'b1);
    addVec(1'b0, 3'd1, 32'h13, 32'h0, 32'h0, 1'b1);
    addVec(1'b0, 3'd6, 32'h00, 32'h0, 32'h0, 1'b1);
    addVec(1'b0, 3'd0, 32'h80000000, 32'h0, 32'h0, 1'b1);

    @(posedge Clk);
    #1 mem_init = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    checkResetOutputs("reset");
    @(posedge Clk);
    #1 Rst = 1'b1;
    @(negedge Clk);
    checkOutput("ready_after_reset", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i, 1'b1);
      waitResponse(i);
    end

    // SB to word 8 aborted by reset in its CAP cycle must leave memory intact
    $display("[TB] reset during read-modify-write");
    v.we = 1'b1; v.f3 = 3'd0; v.addr = 32'h20; v.wdata = 32'h00000077;
    v.rdata = 32'h0; v.err = 1'b0;
    saved_resp = resp_count;
    applyStimulus(v, 100, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    checkOutput("abort_cap_mem_write", {31'b0, mem_write}, 32'd0);
    Rst = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    checkResetOutputs("abort");
    @(posedge Clk);
    #1 Rst = 1'b1;
    @(negedge Clk);
    checkOutput("abort_ready", {31'b0, req_ready}, 32'd1);
    repeat (3) @(negedge Clk);
    checkOutput("abort_no_resp", resp_count, saved_resp);
    checkOutput("abort_no_write", n_writes, 32'd0);

    v.we = 1'b0; v.f3 = 3'd2; v.addr = 32'h20; v.wdata = 32'h0;
    v.rdata = 32'hCAFEF00D; v.err = 1'b0;
    applyStimulus(v, 101, 1'b1);
    waitResponse(101);

    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
